alu_request_arbiter: RTL
========================

// Module: alu_request_arbiter
// PURPOSE
// - Shares the single 32-bit clocked ALU between N_REQ independent requesters (e.g. fetch/branch unit, execute unit).
// - Round-robin arbitrates requests, drives the ALU op/operand bus and waits the ALU's fixed pipeline latency.
// - Captures result and zero/overflow flags, then returns them to the winning requester over a valid/ready channel.
// - One operation in flight at a time.
// PARAMETERS
// - N_REQ        2   number of requesters (2..8)
// - ALU_LATENCY  2   cycles from ALU inputs stable to result+flags valid at ALU outputs (>=1)
// PORTS
// - clk             in   1         system clock, all logic on posedge
// - rst_n           in   1         asynchronous, active-low reset
// - req_valid       in   N_REQ     per-requester request valid
// - req_ready       out  N_REQ     per-requester accept; one-hot or zero
// - req_op          in   3*N_REQ   per-requester ALU op code, slice i = [3i+2:3i]
// - req_a           in   32*N_REQ  per-requester operand A, slice i = [32i+31:32i]
// - req_b           in   32*N_REQ  per-requester operand B
// - rsp_valid       out  1         response valid
// - rsp_ready       in   1         response accepted by consumer
// - rsp_id          out  $clog2(N_REQ)  index of requester this response belongs to
// - rsp_result      out  32        ALU result
// - rsp_zero        out  1         zero flag
// - rsp_overflow    out  1         overflow/carry flag
// - rsp_err         out  1         1 = illegal op code, ALU not used
// - alu_op          out  3         to ALU op select
// - alu_a, alu_b    out  32        to ALU operands
// - alu_result      in   32        from ALU
// - alu_zero        in   1         from ALU
// - alu_overflow    in   1         from ALU
// - busy            out  1         high in any state other than IDLE
// BEHAVIOUR
// - Reset (rst_n=0, immediate): state=IDLE, all outputs 0, rr pointer=0 (requester 0 highest priority first).
// - Legal ops: 000 AND, 001 OR, 010 ADD, 110 SUB, 100 SHL1, 101 SHR1. Codes 011 and 111 are illegal.
// - FSM states: IDLE, EXEC, RESP.
//   - IDLE, no req_valid: stay in IDLE.
//   - IDLE, any req_valid:
//     - Winner = first valid index searching upward from rr pointer, with wrap-around.
//     - req_ready[winner]=1 combinationally in that cycle only.
//     - Latch op/A/B and winner id.
//     - rr pointer <= winner+1 mod N_REQ.
//     - Legal op -> EXEC; illegal op -> RESP with rsp_err=1, result=0, flags=0.
//   - EXEC:
//     - alu_op/alu_a/alu_b driven from latched values, stable for the whole state.
//     - Down-counter loaded with ALU_LATENCY.
//     - On the last EXEC cycle, register alu_result/alu_zero/alu_overflow into the rsp_* registers; -> RESP.
//   - RESP: rsp_valid=1, all rsp_* held constant. Stay until rsp_ready=1, then -> IDLE.
//     - rsp_valid drops the next cycle.
// - Latency:
//   - Accept at cycle t -> ALU inputs valid from t+1 -> rsp_valid at t+ALU_LATENCY+1.
//   - Illegal op: rsp_valid at t+1.
// - Minimum spacing between accepts is ALU_LATENCY+2 cycles; no accept in EXEC or RESP.
// - Requests are not queued. A requester holds valid/op/A/B until it sees req_ready.
//   - Dropping req_valid before it is granted is legal.
// - alu_op/alu_a/alu_b keep their last driven value outside EXEC; no glitch to 0.
// - Simultaneous requests from all requesters: served in rr order, each exactly once per round.
// - rsp_ready high while not in RESP is ignored.
// - Reset mid-EXEC or mid-RESP: operation discarded, no response produced.
//   - The first request after reset is arbitrated from index 0.
// TESTING
// - Single req0 ADD A=5 B=7 -> req_ready[0] one cycle; rsp_valid 3 cycles later (LAT=2).
//   - Expect rsp_result=12, zero=0, id=0, err=0.
// - req0 SUB A=9 B=9 -> rsp_result=0, rsp_zero=1.
//   - Then ADD A=FFFFFFFF B=1 -> rsp_result=0, overflow=1, zero=1.
// - req0 and req1 both valid for 4 ops each -> grants alternate 0,1,0,1...
//   - Each rsp_id matches its grant; no starvation.
// - req1 op=011 -> no EXEC, ALU inputs unchanged; next cycle rsp_valid with rsp_err=1, result=0.
// - Hold rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready stays 0.
//   - rsp_ready=1 -> IDLE next cycle.
// - Assert rst_n=0 during EXEC -> all outputs 0 immediately.
//   - After release, req1 then req0 valid together -> req0 granted first.

Source files
------------

// File: rtl/alu_request_arbiter_if.sv
// alu_request_arbiter_if: requester/response bus between the requesters and the shared-ALU arbiter.
interface alu_request_arbiter_if #(
    parameter int N_REQ = 2
) ();
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [3*N_REQ-1:0]       req_op;
    logic [32*N_REQ-1:0]      req_a;
    logic [32*N_REQ-1:0]      req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [$clog2(N_REQ)-1:0] rsp_id;
    logic [31:0]              rsp_result;
    logic                     rsp_zero;
    logic                     rsp_overflow;
    logic                     rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_err
    );
endinterface

// File: rtl/alu_request_arbiter.sv
// alu_request_arbiter: round-robin sharing of one pipelined 32-bit ALU between N_REQ requesters,
// one operation in flight, result and flags returned over a valid/ready response channel.
module alu_request_arbiter #(
    parameter int N_REQ       = 2,
    parameter int ALU_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_request_arbiter_if.slave bus,
    output logic [2:0]           alu_op,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    input  logic [31:0]          alu_result,
    input  logic                 alu_zero,
    input  logic                 alu_overflow,
    output logic                 busy
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(ALU_LATENCY + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] rr_q, rr_d, id_q, id_d, win, idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d, win_op;
    logic [31:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic          zero_q, zero_d, ovf_q, ovf_d, err_q, err_d, found;

    // Descending scan so the lowest offset from the rr pointer is the last (winning) assignment.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_q) + k) % N_REQ);
            if (bus.req_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign win_op        = bus.req_op[3*win +: 3];
    assign bus.req_ready = (state_q == IDLE && found) ? N_REQ'(1) << win : '0;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        if (state_q == IDLE && found) begin
            id_d = win;
            rr_d = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
            // Codes 011 and 111 share low bits 11; they bypass the ALU and leave its inputs untouched.
            if (win_op[1:0] != 2'b11) begin
                op_d    = win_op;
                a_d     = bus.req_a[32*win +: 32];
                b_d     = bus.req_b[32*win +: 32];
                cnt_d   = CW'(ALU_LATENCY);
                state_d = EXEC;
            end else begin
                res_d   = '0;
                zero_d  = 1'b0;
                ovf_d   = 1'b0;
                err_d   = 1'b1;
                state_d = RESP;
            end
        end else if (state_q == EXEC) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                res_d   = alu_result;
                zero_d  = alu_zero;
                ovf_d   = alu_overflow;
                err_d   = 1'b0;
                state_d = RESP;
            end
        end else if (state_q == RESP && bus.rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign bus.rsp_valid    = state_q == RESP;
    assign bus.rsp_id       = id_q;
    assign bus.rsp_result   = res_q;
    assign bus.rsp_zero     = zero_q;
    assign bus.rsp_overflow = ovf_q;
    assign bus.rsp_err      = err_q;
    assign alu_op           = op_q;
    assign alu_a            = a_q;
    assign alu_b            = b_q;
    assign busy             = state_q != IDLE;
endmodule
